// File: rtl/i2c_eeprom_addr_seq_if.sv
// Bus between the I2C transaction controller (master) and the EEPROM word-address sequencer (slave).
`timescale 1ns/1ps
interface i2c_eeprom_addr_seq_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              i_Start;
    logic              i_Wr_nRd;
    logic [ADDR_W-1:0] i_Start_Addr;
    logic [LEN_W-1:0]  i_Len;
    logic              i_Addr_Byte_Done;
    logic              i_Byte_Done;
    logic              i_Abort;
    logic [ADDR_W-1:0] o_Current_Addr;
    logic [7:0]        o_Addr_Byte;
    logic              o_Addr_Phase;
    logic              o_Data_Phase;
    logic              o_Read_Setting_Flag;
    logic              o_Last_Byte;
    logic [LEN_W-1:0]  o_Remaining;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Page_Split;

    modport master (
        output i_Start, i_Wr_nRd, i_Start_Addr, i_Len, i_Addr_Byte_Done, i_Byte_Done, i_Abort,
        input  o_Current_Addr, o_Addr_Byte, o_Addr_Phase, o_Data_Phase, o_Read_Setting_Flag,
               o_Last_Byte, o_Remaining, o_Busy, o_Done, o_Page_Split
    );

    modport slave (
        input  i_Start, i_Wr_nRd, i_Start_Addr, i_Len, i_Addr_Byte_Done, i_Byte_Done, i_Abort,
        output o_Current_Addr, o_Addr_Byte, o_Addr_Phase, o_Data_Phase, o_Read_Setting_Flag,
               o_Last_Byte, o_Remaining, o_Busy, o_Done, o_Page_Split
    );
endinterface

// File: rtl/i2c_eeprom_addr_seq.sv
// EEPROM word-address sequencer: tracks the device pointer, serialises address bytes MSB first,
// counts burst bytes and splits writes at page boundaries.
`timescale 1ns/1ps
module i2c_eeprom_addr_seq #(
    parameter int ADDR_W    = 8,
    parameter int PAGE_BITS = 3,
    parameter int LEN_W     = 8
) (
    input logic                   i_clk10MHz,
    input logic                   i_RST_n,
    i2c_eeprom_addr_seq_if.slave  bus
);
    localparam int NB    = ADDR_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ADDR, DATA, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [LEN_W-1:0]  rem, rem_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              dir, dir_n;
    logic              ptr_vld, ptr_vld_n;
    logic              flag, flag_n;
    logic              split, split_n;
    logic              page_end;

    function automatic logic [7:0] addr_byte_at(input logic [ADDR_W-1:0] a,
                                                input logic [IDX_W-1:0]  i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NB; k++)
            if (i == IDX_W'(k)) b = a[ADDR_W-1-8*k -: 8];
        return b;
    endfunction

    assign page_end = &cur_addr[PAGE_BITS-1:0];

    always_ff @(posedge i_clk10MHz) begin
        if (!i_RST_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            ptr      <= '0;
            rem      <= '0;
            idx      <= '0;
            dir      <= 1'b0;
            ptr_vld  <= 1'b0;
            flag     <= 1'b0;
            split    <= 1'b0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            ptr      <= ptr_n;
            rem      <= rem_n;
            idx      <= idx_n;
            dir      <= dir_n;
            ptr_vld  <= ptr_vld_n;
            flag     <= flag_n;
            split    <= split_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        ptr_n      = ptr;
        rem_n      = rem;
        idx_n      = idx;
        dir_n      = dir;
        ptr_vld_n  = ptr_vld;
        flag_n     = flag;
        split_n    = split;
        case (state)
            IDLE: begin
                if (bus.i_Start && (bus.i_Len != '0)) begin
                    state_n    = SETUP;
                    cur_addr_n = bus.i_Start_Addr;
                    rem_n      = bus.i_Len;
                    dir_n      = bus.i_Wr_nRd;
                    flag_n     = !bus.i_Wr_nRd && ptr_vld && (ptr == bus.i_Start_Addr);
                end
            end
            SETUP: begin
                idx_n = '0;
                if (bus.i_Abort) begin
                    state_n   = DONE;
                    ptr_vld_n = 1'b0;
                end else begin
                    state_n = flag ? DATA : ADDR;
                end
            end
            ADDR: begin
                if (bus.i_Abort) begin
                    state_n   = DONE;
                    ptr_vld_n = 1'b0;
                end else if (bus.i_Addr_Byte_Done) begin
                    if (idx == IDX_W'(NB - 1)) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.i_Abort) begin
                    state_n   = DONE;
                    ptr_vld_n = 1'b0;
                end else if (bus.i_Byte_Done) begin
                    rem_n      = rem - LEN_W'(1);
                    cur_addr_n = cur_addr + ADDR_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_n = DONE;
                        // A finished read leaves the device pointer one past the last byte;
                        // a write cannot be trusted because the device wraps inside the page.
                        if (dir) begin
                            ptr_vld_n = 1'b0;
                        end else begin
                            ptr_n     = cur_addr + ADDR_W'(1);
                            ptr_vld_n = 1'b1;
                        end
                    end else if (dir && page_end) begin
                        state_n   = DONE;
                        split_n   = 1'b1;
                        ptr_vld_n = 1'b0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                flag_n  = 1'b0;
                split_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.o_Current_Addr      = cur_addr;
    assign bus.o_Remaining         = rem;
    assign bus.o_Addr_Byte         = (state == ADDR) ? addr_byte_at(cur_addr, idx) : 8'h00;
    assign bus.o_Addr_Phase        = (state == ADDR);
    assign bus.o_Data_Phase        = (state == DATA);
    assign bus.o_Read_Setting_Flag = flag;
    assign bus.o_Last_Byte         = (state == DATA) && ((rem == LEN_W'(1)) || (dir && page_end));
    assign bus.o_Busy              = (state != IDLE);
    assign bus.o_Done              = (state == DONE);
    assign bus.o_Page_Split        = split;
endmodule

// File: tb/tb_i2c_eeprom_addr_seq.sv
// Bench for i2c_eeprom_addr_seq: transaction-level reference model with per-cycle compare,
// randomized bursts, plus directed literal checks (16-bit and 8-bit address instances).
`timescale 1ns/1ps
module tb_i2c_eeprom_addr_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    i2c_eeprom_addr_seq_if #(.ADDR_W(16), .LEN_W(8)) bus ();
    i2c_eeprom_addr_seq_if #(.ADDR_W(8),  .LEN_W(8)) bus8 ();

    i2c_eeprom_addr_seq #(.ADDR_W(16), .PAGE_BITS(3), .LEN_W(8)) dut (
        .i_clk10MHz (clk),
        .i_RST_n    (rst_n),
        .bus        (bus)
    );

    i2c_eeprom_addr_seq #(.ADDR_W(8), .PAGE_BITS(3), .LEN_W(8)) dut8 (
        .i_clk10MHz (clk),
        .i_RST_n    (rst_n),
        .bus        (bus8)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;

    // expected outputs of the 16-bit instance for the current cycle
    logic        e_busy, e_ap, e_dp, e_done, e_split, e_flag, e_last;
    logic [15:0] e_cur;
    logic [7:0]  e_rem, e_ab;

    // model of the device's internal pointer as seen by the sequencer
    logic [15:0] m_ptr = '0;
    bit          m_vld = 1'b0;

    logic        seen_flag, seen_split, seen_ap;
    logic [7:0]  seen_ab [2];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("busy",       bus.o_Busy,                e_busy);
            cmp("addr_phase", bus.o_Addr_Phase,          e_ap);
            cmp("data_phase", bus.o_Data_Phase,          e_dp);
            cmp("done",       bus.o_Done,                e_done);
            cmp("page_split", bus.o_Page_Split,          e_split);
            cmp("rd_flag",    bus.o_Read_Setting_Flag,   e_flag);
            cmp("last_byte",  bus.o_Last_Byte,           e_last);
            cmp("cur_addr",   bus.o_Current_Addr,        e_cur);
            cmp("remaining",  bus.o_Remaining,           e_rem);
            cmp("addr_byte",  bus.o_Addr_Byte,           e_ab);
        end
    end

    task automatic set_exp(input logic busy, input logic ap, input logic dp, input logic done,
                           input logic split, input logic flag, input logic [15:0] cur,
                           input logic [7:0] rem, input logic last, input logic [7:0] ab);
        e_busy = busy; e_ap = ap; e_dp = dp; e_done = done; e_split = split;
        e_flag = flag; e_cur = cur; e_rem = rem; e_last = last; e_ab = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_Start          = 1'b0;
        bus.i_Addr_Byte_Done = 1'b0;
        bus.i_Byte_Done      = 1'b0;
        bus.i_Abort          = 1'b0;
        bus.i_Wr_nRd         = 1'($urandom);
        bus.i_Start_Addr     = 16'($urandom);
        bus.i_Len            = 8'($urandom);
    endtask

    task automatic tick8();
        @(posedge clk);
        #1;
        bus8.i_Start          = 1'b0;
        bus8.i_Addr_Byte_Done = 1'b0;
        bus8.i_Byte_Done      = 1'b0;
        bus8.i_Abort          = 1'b0;
    endtask

    // One burst. ab_mode: 0 none, 1 abort in SETUP, 2 abort with address byte ab_k,
    // 3 abort together with data byte ab_k.
    task automatic run_txn(input bit wr, input logic [15:0] a0, input logic [7:0] len,
                           input int ab_mode, input int ab_k);
        logic [15:0] a;
        logic [7:0]  r;
        bit flg, split, aborted, page_last;
        int n;
        bus.i_Start = 1'b1; bus.i_Wr_nRd = wr; bus.i_Start_Addr = a0; bus.i_Len = len;
        tick();
        if (len == 8'd0) return;
        flg = !wr && m_vld && (m_ptr == a0);
        a = a0; r = len; split = 1'b0; aborted = 1'b0; n = 0;
        set_exp(1, 0, 0, 0, 0, flg, a, r, 0, 8'h00);
        @(negedge clk); #1;
        seen_flag = bus.o_Read_Setting_Flag;
        if (ab_mode == 1) begin
            bus.i_Abort = 1'b1;
            tick();
            aborted = 1'b1;
        end else begin
            bus.i_Byte_Done = 1'($urandom);
            tick();
            if (!flg) set_exp(1, 1, 0, 0, 0, flg, a, r, 0, a[15:8]);
            else      set_exp(1, 0, 1, 0, 0, flg, a, r, (r == 8'd1) || (wr && a[2:0] == 3'b111), 8'h00);
            @(negedge clk); #1;
            seen_ap = bus.o_Addr_Phase;
            seen_ab[0] = bus.o_Addr_Byte;
            if (!flg) begin
                for (int k = 0; k < 2; k++) begin
                    if (k == 1) begin
                        set_exp(1, 1, 0, 0, 0, flg, a, r, 0, a[7:0]);
                        @(negedge clk); #1;
                        seen_ab[1] = bus.o_Addr_Byte;
                    end
                    repeat ($urandom_range(0, 2)) begin
                        bus.i_Byte_Done = 1'($urandom);
                        tick();
                    end
                    bus.i_Addr_Byte_Done = 1'b1;
                    if (ab_mode == 2 && k == ab_k) begin
                        bus.i_Abort = 1'b1;
                        tick();
                        aborted = 1'b1;
                        break;
                    end
                    tick();
                end
            end
            while (!aborted) begin
                set_exp(1, 0, 1, 0, 0, flg, a, r, (r == 8'd1) || (wr && a[2:0] == 3'b111), 8'h00);
                repeat ($urandom_range(0, 2)) begin
                    bus.i_Addr_Byte_Done = 1'($urandom);
                    bus.i_Start = 1'($urandom);
                    tick();
                end
                bus.i_Byte_Done = 1'b1;
                if (ab_mode == 3 && n == ab_k) begin
                    bus.i_Abort = 1'b1;
                    tick();
                    aborted = 1'b1;
                    break;
                end
                tick();
                page_last = (a[2:0] == 3'b111);
                a = a + 16'd1;
                r = r - 8'd1;
                n++;
                if (r == 8'd0) break;
                if (wr && page_last) begin
                    split = 1'b1;
                    break;
                end
            end
        end
        set_exp(1, 0, 0, 1, split, flg, a, r, 0, 8'h00);
        if (aborted || wr) m_vld = 1'b0;
        else begin
            m_ptr = a;
            m_vld = 1'b1;
        end
        @(negedge clk); #1;
        seen_split = bus.o_Page_Split;
        bus.i_Start = 1'($urandom);
        tick();
        set_exp(0, 0, 0, 0, 0, 0, a, r, 0, 8'h00);
    endtask

    task automatic reset_mid(input logic [15:0] a0);
        bus.i_Start = 1'b1; bus.i_Wr_nRd = 1'b1; bus.i_Start_Addr = a0; bus.i_Len = 8'd4;
        tick();
        set_exp(1, 0, 0, 0, 0, 0, a0, 8'd4, 0, 8'h00);
        tick();
        set_exp(1, 1, 0, 0, 0, 0, a0, 8'd4, 0, a0[15:8]);
        @(negedge clk); #1;
        rst_n = 1'b0;
        tick();
        set_exp(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00);
        m_vld = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic random_phase();
        logic [15:0] a;
        logic [7:0]  len;
        int mode, k;
        bit wr;
        for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       a = m_ptr;
                1:       a = {13'($urandom), 1'b1, 2'($urandom)};
                2:       a = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: a = 16'($urandom);
            endcase
            len = 8'($urandom_range(0, 10));
            case ($urandom_range(0, 9))
                0:       begin mode = 1; k = 0; end
                1:       begin mode = 2; k = $urandom_range(0, 1); end
                2:       begin mode = 3; k = $urandom_range(0, 5); end
                default: begin mode = 0; k = 0; end
            endcase
            run_txn(wr, a, len, mode, k);
            repeat ($urandom_range(0, 2)) begin
                bus.i_Byte_Done = 1'($urandom);
                bus.i_Abort = 1'($urandom);
                bus.i_Addr_Byte_Done = 1'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp8 [3];
        exp8[0] = 8'hFF; exp8[1] = 8'h00; exp8[2] = 8'h01;
        bus.i_Start = 0; bus.i_Wr_nRd = 0; bus.i_Start_Addr = '0; bus.i_Len = '0;
        bus.i_Addr_Byte_Done = 0; bus.i_Byte_Done = 0; bus.i_Abort = 0;
        bus8.i_Start = 0; bus8.i_Wr_nRd = 0; bus8.i_Start_Addr = '0; bus8.i_Len = '0;
        bus8.i_Addr_Byte_Done = 0; bus8.i_Byte_Done = 0; bus8.i_Abort = 0;
        tick();
        set_exp(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00);
        chk_on = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        run_txn(0, 16'h0055, 8'd0, 0, 0);
        @(negedge clk); #1;
        cmp("len0_busy", bus.o_Busy, 0);

        run_txn(0, 16'h1234, 8'd3, 0, 0);
        @(negedge clk); #1;
        cmp("t1_addr_byte0", seen_ab[0], 8'h12);
        cmp("t1_addr_byte1", seen_ab[1], 8'h34);
        cmp("t1_end_addr", bus.o_Current_Addr, 16'h1237);
        cmp("t1_end_rem", bus.o_Remaining, 8'd0);

        run_txn(0, 16'h0010, 8'd2, 0, 0);
        run_txn(0, 16'h0012, 8'd1, 0, 0);
        cmp("t2_flag_hit", seen_flag, 1);
        cmp("t2_skip_addr", seen_ap, 0);
        run_txn(0, 16'h0020, 8'd1, 0, 0);
        cmp("t2_flag_miss", seen_flag, 0);
        cmp("t2_takes_addr", seen_ap, 1);

        run_txn(1, 16'h0006, 8'd5, 0, 0);
        @(negedge clk); #1;
        cmp("t3_split", seen_split, 1);
        cmp("t3_split_addr", bus.o_Current_Addr, 16'h0008);
        cmp("t3_split_rem", bus.o_Remaining, 8'd3);
        run_txn(1, 16'h0008, 8'd3, 0, 0);
        @(negedge clk); #1;
        cmp("t3_restart_split", seen_split, 0);
        cmp("t3_restart_addr", bus.o_Current_Addr, 16'h000B);

        run_txn(0, 16'hFFFE, 8'd3, 0, 0);
        @(negedge clk); #1;
        cmp("wrap16_addr", bus.o_Current_Addr, 16'h0001);

        run_txn(0, 16'h0040, 8'd2, 0, 0);
        run_txn(0, 16'h0042, 8'd3, 3, 1);
        @(negedge clk); #1;
        cmp("t5_abort_addr", bus.o_Current_Addr, 16'h0043);
        cmp("t5_abort_rem", bus.o_Remaining, 8'd2);
        run_txn(0, 16'h0042, 8'd1, 0, 0);
        cmp("t5_ptr_cleared", seen_flag, 0);

        reset_mid(16'h3456);
        random_phase();
        chk_on = 1'b0;

        bus8.i_Wr_nRd = 1'b0; bus8.i_Start_Addr = 8'hFE; bus8.i_Len = 8'd3; bus8.i_Start = 1'b1;
        tick8();
        tick8();
        @(negedge clk);
        cmp("a8_addr_phase", bus8.o_Addr_Phase, 1);
        cmp("a8_addr_byte", bus8.o_Addr_Byte, 8'hFE);
        bus8.i_Addr_Byte_Done = 1'b1;
        tick8();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("a8_last", bus8.o_Last_Byte, (i == 2));
            bus8.i_Byte_Done = 1'b1;
            tick8();
            @(negedge clk);
            cmp("a8_addr", bus8.o_Current_Addr, exp8[i]);
        end
        cmp("a8_done", bus8.o_Done, 1);
        cmp("a8_split", bus8.o_Page_Split, 0);
        cmp("a8_rem", bus8.o_Remaining, 8'd0);
        tick8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
